// File: rtl/time_uart_pkg.sv
// rtl/time_uart_pkg.sv - shared types and constants for the time report transmitter
package time_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  // Characters per report: "HH:MM:SS" plus CR LF
  localparam int FRAME_LEN = 10;

endpackage

// File: rtl/time_uart_tx_bin2bcd6.sv
// rtl/time_uart_tx_bin2bcd6.sv - 6-bit binary to two BCD digits by threshold compare
module bin2bcd6 (
  input  logic [5:0] v,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [2:0] t;

  // Tens is the number of decade thresholds reached; 60..63 keep tens=6 so they print as-is
  always_comb begin
    t = {2'b00, v >= 6'd10} + {2'b00, v >= 6'd20} + {2'b00, v >= 6'd30}
      + {2'b00, v >= 6'd40} + {2'b00, v >= 6'd50} + {2'b00, v >= 6'd60};
  end

  assign tens = {1'b0, t};
  // ones < 10, so only the low nibble of v - 10*t matters; 10*t = 8*t + 2*t
  assign ones = v[3:0] - {t[0], 3'b000} - {t, 1'b0};

endmodule

// File: rtl/time_uart_tx.sv
// rtl/time_uart_tx.sv - sends "HH:MM:SS\r\n" as UART 8N1 on a send edge or seconds change
module time_uart_tx
  import time_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       send,
  input  logic       auto_en,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  state_t          state, state_nx;
  logic            send_d;
  logic [5:0]      sec_d;
  logic            req;
  logic            pending;
  logic [17:0]     shadow;
  logic [3:0]      char_idx;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   baud_cnt;
  logic            baud_last;
  logic            last_char;
  logic [7:0]      shreg;
  logic [7:0]      char_byte;
  logic [3:0]      h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;

  assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_char = (char_idx == 4'(FRAME_LEN - 1));

  bin2bcd6 u_hour (.v(shadow[17:12]), .tens(h_tens), .ones(h_ones));
  bin2bcd6 u_min  (.v(shadow[11:6]),  .tens(m_tens), .ones(m_ones));
  bin2bcd6 u_sec  (.v(shadow[5:0]),   .tens(s_tens), .ones(s_ones));

  // Request edge detection; a request arriving outside IDLE is remembered once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_d  <= 1'b0;
      sec_d   <= sec;
      req     <= 1'b0;
      pending <= 1'b0;
    end else begin
      send_d <= send;
      sec_d  <= sec;
      req    <= (send & ~send_d) | (auto_en & (sec != sec_d));
      if (state == ST_IDLE) begin
        pending <= 1'b0;
      end else if (req) begin
        pending <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus line and busy outputs decoded from the current state
  always_comb begin
    state_nx = state;
    txd      = 1'b1;
    busy     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req || pending) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        state_nx = ST_START;
      end
      ST_START: begin
        txd  = 1'b0;
        busy = 1'b1;
        if (baud_last) state_nx = ST_DATA;
      end
      ST_DATA: begin
        txd  = shreg[0];
        busy = 1'b1;
        if (baud_last && bit_idx == 3'd7) state_nx = ST_STOP;
      end
      ST_STOP: begin
        busy = 1'b1;
        if (baud_last) state_nx = last_char ? ST_IDLE : ST_START;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Character selected by position in the frame
  always_comb begin
    char_byte = ASC_LF;
    case (char_idx)
      4'd0:    char_byte = ASC_0 + {4'b0000, h_tens};
      4'd1:    char_byte = ASC_0 + {4'b0000, h_ones};
      4'd2:    char_byte = ASC_COLON;
      4'd3:    char_byte = ASC_0 + {4'b0000, m_tens};
      4'd4:    char_byte = ASC_0 + {4'b0000, m_ones};
      4'd5:    char_byte = ASC_COLON;
      4'd6:    char_byte = ASC_0 + {4'b0000, s_tens};
      4'd7:    char_byte = ASC_0 + {4'b0000, s_ones};
      4'd8:    char_byte = ASC_CR;
      default: char_byte = ASC_LF;
    endcase
  end

  // Baud timing, snapshot, shifter and frame-complete pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      shadow   <= '0;
      char_idx <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_nx != state || state == ST_IDLE || state == ST_LOAD || baud_last) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      case (state)
        ST_LOAD: begin
          shadow   <= {hour, min, sec};
          char_idx <= 4'd0;
        end
        ST_START: begin
          if (baud_last) begin
            shreg   <= char_byte;
            bit_idx <= 3'd0;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          if (baud_last) begin
            if (last_char) done <= 1'b1;
            else           char_idx <= char_idx + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_uart_tx.sv
// tb/tb_time_uart_tx.sv - self-checking bench for time_uart_tx
module tb_time_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic       send = 1'b0;
  logic       auto_en = 1'b0;
  logic       txd, busy, done;

  time_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .hour(hour), .min(min), .sec(sec),
    .send(send), .auto_en(auto_en), .txd(txd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Free-running line monitor: counts busy cycles, done pulses and busy rises
  int   cyc = 0, done_total = 0, busy_total = 0, rise_total = 0;
  int   done_cyc [64];
  int   rise_cyc [64];
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= busy;
    if (busy === 1'b1) busy_total <= busy_total + 1;
    if (done === 1'b1) begin
      done_total <= done_total + 1;
      done_cyc[done_total % 64] <= cyc + 1;
    end
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      rise_total <= rise_total + 1;
      rise_cyc[rise_total % 64] <= cyc + 1;
    end
  end

  // Behavioural UART receiver: samples each bit mid-way
  logic [7:0] rx_buf [0:1023];
  int         rx_wr = 0;
  int         frame_err = 0;
  initial begin : decoder
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && txd === 1'b0) begin
        repeat (CPB + 1) @(negedge clk);
        b[0] = txd;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        if (txd !== 1'b1) frame_err++;
        rx_buf[rx_wr % 1024] = b;
        rx_wr++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string model(input int h, input int m, input int s);
    return $sformatf("%02d:%02d:%02d%c%c", h, m, s, 8'h0D, 8'h0A);
  endfunction

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "<CR>"};
      else if (s[i] == 8'h0A) r = {r, "<LF>"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(act), vis(exp));
    end
  endtask

  int c0, d0, r0, b0, rd0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic mark();
    d0 = done_total; r0 = rise_total; b0 = busy_total; rd0 = rx_wr; c0 = cyc;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    tick(2);
    send = 1'b0;
  endtask

  task automatic start_send(input int h, input int m, input int s);
    tick(1);
    hour = 6'(h); min = 6'(m); sec = 6'(s);
    mark();
    pulse_send();
  endtask

  task automatic finish_frame(input string name, input string exp, input int nframes);
    int    n = 0;
    string got = "";
    while (done_total < d0 + nframes && n < 3000) begin
      tick(1);
      n++;
    end
    check(done_total >= d0 + nframes, {name, " done timeout"}, done_total - d0, nframes);
    tick(5);
    check(done_total - d0 == nframes, {name, " done pulses"}, done_total - d0, nframes);
    check(busy_total - b0 == 100 * CPB * nframes, {name, " busy cycles"}, busy_total - b0,
          100 * CPB * nframes);
    check(rise_total > r0 && rise_cyc[r0 % 64] - c0 == 3, {name, " start latency"},
          rise_cyc[r0 % 64] - c0, 3);
    check(rx_wr - rd0 == 10 * nframes, {name, " byte count"}, rx_wr - rd0, 10 * nframes);
    for (int i = rd0; i < rx_wr; i++) got = $sformatf("%s%c", got, rx_buf[i % 1024]);
    check_str({name, " text"}, got, exp);
  endtask

  typedef struct {
    int    h;
    int    m;
    int    s;
    string exp;
  } vec_t;

  initial begin : main
    vec_t tbl[$];
    int   bad;
    int   h, m, s;

    tbl.push_back('{13,  5,  9, "13:05:09\015\012"});
    tbl.push_back('{ 0,  0,  0, "00:00:00\015\012"});
    tbl.push_back('{23, 59, 59, "23:59:59\015\012"});
    tbl.push_back('{ 7, 40, 63, "07:40:63\015\012"});
    tbl.push_back('{63, 60, 10, "63:60:10\015\012"});

    // Reset state
    tick(5);
    check(txd === 1'b1, "reset txd", int'(txd), 1);
    check(busy === 1'b0, "reset busy", int'(busy), 0);
    check(done === 1'b0, "reset done", int'(done), 0);
    reset = 1'b1;
    bad = 0;
    mark();
    repeat (1000) begin
      tick(1);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check(bad == 0, "idle activity", bad, 0);
    check(rx_wr == rd0, "idle bytes", rx_wr - rd0, 0);

    // Table vectors
    foreach (tbl[i]) begin
      start_send(tbl[i].h, tbl[i].m, tbl[i].s);
      finish_frame($sformatf("vec%0d", i), tbl[i].exp, 1);
      tick(20);
    end

    // Snapshot hold: inputs change mid-frame
    start_send(23, 59, 59);
    tick(150);
    hour = 6'd0; min = 6'd0; sec = 6'd0;
    finish_frame("snapshot", model(23, 59, 59), 1);

    // Auto mode: each seconds change sends one frame
    hour = 6'd10; min = 6'd20; sec = 6'd57;
    tick(3);
    auto_en = 1'b1;
    mark();
    tick(10);
    check(rise_total == r0, "auto no change", rise_total - r0, 0);
    mark();
    sec = 6'd58;
    finish_frame("auto58", model(10, 20, 58), 1);
    tick(600);
    mark();
    sec = 6'd59;
    finish_frame("auto59", model(10, 20, 59), 1);
    tick(20);

    // Send edge and seconds change together make one request
    mark();
    sec = 6'd0;
    pulse_send();
    finish_frame("send+auto", model(10, 20, 0), 1);
    tick(500);
    check(done_total - d0 == 1, "send+auto single", done_total - d0, 1);
    auto_en = 1'b0;
    tick(5);

    // Pending: three edges during a frame yield one extra frame
    start_send(1, 2, 3);
    tick(100); pulse_send();
    tick(100); pulse_send();
    tick(100); pulse_send();
    finish_frame("pending", {model(1, 2, 3), model(1, 2, 3)}, 2);
    check(rise_total > r0 + 1 && rise_cyc[(r0 + 1) % 64] - done_cyc[d0 % 64] == 2, "pending gap",
          rise_cyc[(r0 + 1) % 64] - done_cyc[d0 % 64], 2);
    tick(600);
    check(done_total - d0 == 2, "pending total", done_total - d0, 2);

    // Reset at char 4 bit 3 ('0' has bit 3 clear)
    start_send(4, 0, 7);
    while (cyc < c0 + 3 + 40 * CPB + 4 * CPB + CPB / 2) tick(1);
    check(txd === 1'b0, "pre-abort txd", int'(txd), 0);
    reset = 1'b0;
    #1;
    check(txd === 1'b1, "abort txd", int'(txd), 1);
    check(busy === 1'b0, "abort busy", int'(busy), 0);
    tick(3);
    check(done_total == d0, "abort no done", done_total - d0, 0);
    reset = 1'b1;
    tick(100);
    start_send(12, 34, 56);
    finish_frame("post-reset", model(12, 34, 56), 1);

    // Random vectors against the string model
    repeat (6) begin
      h = $urandom_range(0, 23);
      m = $urandom_range(0, 59);
      s = $urandom_range(0, 63);
      start_send(h, m, s);
      finish_frame($sformatf("rand %0d:%0d:%0d", h, m, s), model(h, m, s), 1);
      tick(int'($urandom_range(0, 30)));
    end

    check(frame_err == 0, "stop bits", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
